node_round_sequencer: RTL

- Per-node round controller for the Q-learning routing datapath.
- Starts each processing stage in a fixed order with a start/done handshake: receive/update, selectMyAction, aggregation, transmit.
- Owns the single 16-bit node memory write port and muxes it to whichever stage is active.
- At the end of each round it writes the round counter to memory; it aborts the round if a stage hangs.

---
 rtl/node_round_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/node_round_sequencer.sv
// node_round_sequencer: per-node round controller for the Q-learning routing datapath.
// Runs the enabled stages in ascending index order (receive/update, selectMyAction,
// aggregation, transmit) with a start/done handshake. It owns the single node memory
// write port, writes the incremented round count at the end of each round, and
// aborts the round when a stage stays in WAIT for TIMEOUT cycles.
//
// Ports:
//   clock, rst             clock, asynchronous active-high reset
//   round_start            round request, accepted only when idle
//   stage_en               per-stage enable, latched when a round is accepted
//   stage_done             per-stage completion; only the active stage is observed
//   stage_addr/_wr_en/_data  flattened per-stage memory requests (stage k at [k*W +: W])
//   stage_start            one-cycle start pulse to the selected stage
//   mem_addr/_wr_en/_data  node memory write port
//   active_stage           index of the current stage, 0 when idle
//   busy                   high from round acceptance until return to idle
//   round_done             one-cycle pulse on successful completion
//   timeout_err            sticky abort flag, cleared when the next round is accepted
//   round_count            number of completed rounds (wraps)
module node_round_sequencer #(
  parameter int unsigned           NUM_STAGES = 4,
  parameter int unsigned           WORD_WIDTH = 16,
  parameter int unsigned           TIMEOUT    = 1024,
  parameter logic [WORD_WIDTH-1:0] ROUND_ADDR = 'h7FF
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic                             round_start,
  input  logic [NUM_STAGES-1:0]            stage_en,
  input  logic [NUM_STAGES-1:0]            stage_done,
  input  logic [NUM_STAGES*WORD_WIDTH-1:0] stage_addr,
  input  logic [NUM_STAGES-1:0]            stage_wr_en,
  input  logic [NUM_STAGES*WORD_WIDTH-1:0] stage_data,
  output logic [NUM_STAGES-1:0]            stage_start,
  output logic [WORD_WIDTH-1:0]            mem_addr,
  output logic                             mem_wr_en,
  output logic [WORD_WIDTH-1:0]            mem_data,
  output logic [2:0]                       active_stage,
  output logic                             busy,
  output logic                             round_done,
  output logic                             timeout_err,
  output logic [WORD_WIDTH-1:0]            round_count
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [NUM_STAGES-1:0] START_ONE = NUM_STAGES'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StNext,
    StFinish,
    StDone,
    StAbort
  } state_e;

  state_e                state_q;
  logic [NUM_STAGES-1:0] en_q;
  logic [2:0]            k_q;
  logic [TW-1:0]         timer_q;

  logic                  first_any;
  logic [2:0]            first_idx;
  logic                  next_any;
  logic [2:0]            next_idx;
  logic [WORD_WIDTH-1:0] sel_addr;
  logic [WORD_WIDTH-1:0] sel_data;
  logic                  sel_wr_en;
  logic                  sel_done;

  // Lowest enabled stage of the incoming request; the enable mask is being latched
  // on the same edge, so the live input is searched rather than en_q.
  always_comb begin
    first_any = 1'b0;
    first_idx = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (stage_en[i] && !first_any) begin
        first_any = 1'b1;
        first_idx = 3'(i);
      end
    end
  end

  // Next enabled stage strictly above the one that just finished.
  always_comb begin
    next_any = 1'b0;
    next_idx = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (en_q[i] && (3'(i) > k_q) && !next_any) begin
        next_any = 1'b1;
        next_idx = 3'(i);
      end
    end
  end

  // Select the active stage's request signals.
  always_comb begin
    sel_addr  = '0;
    sel_data  = '0;
    sel_wr_en = 1'b0;
    sel_done  = 1'b0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (k_q == 3'(i)) begin
        sel_addr  = stage_addr[i*WORD_WIDTH +: WORD_WIDTH];
        sel_data  = stage_data[i*WORD_WIDTH +: WORD_WIDTH];
        sel_wr_en = stage_wr_en[i];
        sel_done  = stage_done[i];
      end
    end
  end

  // Memory port: follows the active stage during WAIT, carries the round-count write
  // during FINISH, and is held at zero otherwise.
  always_comb begin
    mem_addr  = '0;
    mem_wr_en = 1'b0;
    mem_data  = '0;
    if (state_q == StWait) begin
      mem_addr  = sel_addr;
      mem_wr_en = sel_wr_en;
      mem_data  = sel_data;
    end else if (state_q == StFinish) begin
      mem_addr  = ROUND_ADDR;
      mem_wr_en = 1'b1;
      mem_data  = round_count + WORD_WIDTH'(1);
    end
  end

  assign active_stage = k_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      en_q        <= '0;
      k_q         <= '0;
      timer_q     <= '0;
      stage_start <= '0;
      busy        <= 1'b0;
      round_done  <= 1'b0;
      timeout_err <= 1'b0;
      round_count <= '0;
    end else begin
      stage_start <= '0;
      round_done  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (round_start) begin
            en_q        <= stage_en;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            if (first_any) begin
              k_q         <= first_idx;
              stage_start <= START_ONE << first_idx;
              state_q     <= StStart;
            end else begin
              state_q <= StFinish;
            end
          end
        end
        StStart: begin
          timer_q <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // Done wins over the timeout limit when both arrive together.
          if (sel_done) begin
            state_q <= StNext;
          end else if (timer_q == TIMER_LAST) begin
            state_q <= StAbort;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StNext: begin
          if (next_any) begin
            k_q         <= next_idx;
            stage_start <= START_ONE << next_idx;
            state_q     <= StStart;
          end else begin
            state_q <= StFinish;
          end
        end
        StFinish: begin
          round_count <= round_count + WORD_WIDTH'(1);
          round_done  <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          busy    <= 1'b0;
          k_q     <= '0;
          state_q <= StIdle;
        end
        StAbort: begin
          timeout_err <= 1'b1;
          busy        <= 1'b0;
          k_q         <= '0;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
